sync_fifo_flex: RTL and testbench

SYNC_FIFO_FLEX -- requirements
Module: sync_fifo_flex

---
 rtl/sync_fifo_memory.sv | 53 +++++
 rtl/sync_fifo_flex.sv | 120 ++++++++++++
 tb/tb_sync_fifo_flex.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_memory.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_memory
// Purpose  : Storage array for sync_fifo_flex with one write port and one read port.
//            The read port is registered when fwft is 0 and combinational when fwft is 1.
// Revision : 1.0
// ============================================================================
module sync_fifo_memory #(
   parameter int DATA_SIZE = 8,
   parameter int ADDR_SIZE = 8,
   parameter int FWFT      = 0
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 wr_en,
   input  logic [ADDR_SIZE-1:0] wr_addr,
   input  logic [DATA_SIZE-1:0] wr_data,
   input  logic                 rd_en,
   input  logic [ADDR_SIZE-1:0] rd_addr,
   output logic [DATA_SIZE-1:0] rd_data
);

   localparam int C_WORDS = 1 << ADDR_SIZE;

   logic [DATA_SIZE-1:0] r_mem [0:C_WORDS-1];

   // The array has no reset so that it can map onto RAM primitives.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         r_mem[wr_addr] <= wr_data;
      end
   end

   generate
      if (FWFT != 0) begin : g_comb_read
         assign rd_data = r_mem[rd_addr];
      end else begin : g_reg_read
         logic [DATA_SIZE-1:0] r_rd_data;

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               r_rd_data <= '0;
            end else if (rd_en) begin
               r_rd_data <= r_mem[rd_addr];
            end
         end

         assign rd_data = r_rd_data;
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/sync_fifo_flex.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_flex
// Purpose  : Single-clock FIFO with full, empty and threshold flags, sticky
//            error flags, synchronous clear, and a registered or FWFT read port.
// Revision : 1.0
// ============================================================================
module sync_fifo_flex #(
   parameter int fifo_data_size     = 8,
   parameter int fifo_ptr_size      = 8,
   parameter int almost_full_space  = 10,
   parameter int almost_empty_space = 2,
   parameter int fwft               = 0
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      wr_valid,
   input  logic [fifo_data_size-1:0] wr_data,
   input  logic                      rd_valid,
   input  logic                      clear,
   output logic [fifo_data_size-1:0] rd_data,
   output logic                      rd_data_valid,
   output logic                      fifo_full,
   output logic                      fifo_empty,
   output logic                      fifo_almost_full,
   output logic                      fifo_almost_empty,
   output logic [fifo_ptr_size:0]    fifo_depth,
   output logic                      overflow,
   output logic                      underflow
);

   localparam int fifo_size = 1 << fifo_ptr_size;
   localparam logic [fifo_ptr_size:0] C_SIZE     = (fifo_ptr_size+1)'(fifo_size);
   localparam logic [fifo_ptr_size:0] C_AF_SPACE = (fifo_ptr_size+1)'(almost_full_space);
   localparam logic [fifo_ptr_size:0] C_AE_SPACE = (fifo_ptr_size+1)'(almost_empty_space);

   generate
      if (almost_full_space >= fifo_size || almost_empty_space >= fifo_size) begin : g_bad_params
         $error("sync_fifo_flex: almost_full_space and almost_empty_space must be below fifo_size");
      end
   endgenerate

   logic [fifo_ptr_size:0]    r_wr_ptr;
   logic [fifo_ptr_size:0]    r_rd_ptr;
   logic                      r_overflow;
   logic                      r_underflow;
   logic                      w_wr_accept;
   logic                      w_rd_accept;
   logic [fifo_data_size-1:0] w_mem_rd_data;

   // The extra pointer MSB makes full and empty distinct once the pointers wrap.
   assign fifo_depth        = r_wr_ptr - r_rd_ptr;
   assign fifo_empty        = (fifo_depth == '0);
   assign fifo_full         = (fifo_depth == C_SIZE);
   assign fifo_almost_full  = ((C_SIZE - fifo_depth) <= C_AF_SPACE);
   assign fifo_almost_empty = (fifo_depth <= C_AE_SPACE);

   assign w_wr_accept = wr_valid && !fifo_full  && !clear;
   assign w_rd_accept = rd_valid && !fifo_empty && !clear;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else if (clear) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (w_wr_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_rd_accept) r_rd_ptr <= r_rd_ptr + 1'b1;
         if (wr_valid && fifo_full)  r_overflow  <= 1'b1;
         if (rd_valid && fifo_empty) r_underflow <= 1'b1;
      end
   end

   assign overflow  = r_overflow;
   assign underflow = r_underflow;

   sync_fifo_memory #(
      .DATA_SIZE (fifo_data_size),
      .ADDR_SIZE (fifo_ptr_size),
      .FWFT      (fwft)
   ) u_mem (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_en   (w_wr_accept),
      .wr_addr (r_wr_ptr[fifo_ptr_size-1:0]),
      .wr_data (wr_data),
      .rd_en   (w_rd_accept),
      .rd_addr (r_rd_ptr[fifo_ptr_size-1:0]),
      .rd_data (w_mem_rd_data)
   );

   generate
      if (fwft != 0) begin : g_fwft_out
         // Masking on empty keeps the unreset array contents off rd_data.
         assign rd_data       = fifo_empty ? '0 : w_mem_rd_data;
         assign rd_data_valid = !fifo_empty;
      end else begin : g_reg_out
         logic r_rd_data_valid;

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               r_rd_data_valid <= 1'b0;
            end else begin
               r_rd_data_valid <= w_rd_accept;
            end
         end

         assign rd_data       = w_mem_rd_data;
         assign rd_data_valid = r_rd_data_valid;
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_flex.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_fifo_flex
// Purpose  : Drives a registered-read and an FWFT instance with the same stimulus
//            and compares both against a queue-based reference model.
// Revision : 1.0
// ============================================================================
module tb_sync_fifo_flex;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       wr_valid;
   logic [7:0] wr_data;
   logic       rd_valid;
   logic       clear;

   logic [7:0] rd_data_r, rd_data_f;
   logic       rd_data_valid_r, rd_data_valid_f;
   logic       full_r, full_f, empty_r, empty_f;
   logic       afull_r, afull_f, aempty_r, aempty_f;
   logic [3:0] depth_r, depth_f;
   logic       ovf_r, ovf_f, udf_r, udf_f;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] q[$];
   bit         m_ovf;
   bit         m_udf;
   bit         m_v0;
   logic [7:0] m_rd0;

   always #5 clk = ~clk;

   sync_fifo_flex #(
      .fifo_data_size(8), .fifo_ptr_size(3), .almost_full_space(2),
      .almost_empty_space(1), .fwft(0)
   ) u_dut_reg (
      .clk(clk), .reset_n(reset_n), .wr_valid(wr_valid), .wr_data(wr_data),
      .rd_valid(rd_valid), .clear(clear), .rd_data(rd_data_r),
      .rd_data_valid(rd_data_valid_r), .fifo_full(full_r), .fifo_empty(empty_r),
      .fifo_almost_full(afull_r), .fifo_almost_empty(aempty_r),
      .fifo_depth(depth_r), .overflow(ovf_r), .underflow(udf_r)
   );

   sync_fifo_flex #(
      .fifo_data_size(8), .fifo_ptr_size(3), .almost_full_space(2),
      .almost_empty_space(1), .fwft(1)
   ) u_dut_fwft (
      .clk(clk), .reset_n(reset_n), .wr_valid(wr_valid), .wr_data(wr_data),
      .rd_valid(rd_valid), .clear(clear), .rd_data(rd_data_f),
      .rd_data_valid(rd_data_valid_f), .fifo_full(full_f), .fifo_empty(empty_f),
      .fifo_almost_full(afull_f), .fifo_almost_empty(aempty_f),
      .fifo_depth(depth_f), .overflow(ovf_f), .underflow(udf_f)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_all();
      int         d;
      logic [7:0] head;
      d    = q.size();
      head = (d == 0) ? 8'h00 : q[0];
      check("depth_r",  32'(depth_r),  32'(d));
      check("depth_f",  32'(depth_f),  32'(d));
      check("empty_r",  32'(empty_r),  32'(d == 0));
      check("empty_f",  32'(empty_f),  32'(d == 0));
      check("full_r",   32'(full_r),   32'(d == 8));
      check("full_f",   32'(full_f),   32'(d == 8));
      check("afull_r",  32'(afull_r),  32'((8 - d) <= 2));
      check("afull_f",  32'(afull_f),  32'((8 - d) <= 2));
      check("aempty_r", 32'(aempty_r), 32'(d <= 1));
      check("aempty_f", 32'(aempty_f), 32'(d <= 1));
      check("ovf_r",    32'(ovf_r),    32'(m_ovf));
      check("ovf_f",    32'(ovf_f),    32'(m_ovf));
      check("udf_r",    32'(udf_r),    32'(m_udf));
      check("udf_f",    32'(udf_f),    32'(m_udf));
      check("rdv_r",    32'(rd_data_valid_r), 32'(m_v0));
      check("rdata_r",  32'(rd_data_r),       32'(m_rd0));
      check("rdv_f",    32'(rd_data_valid_f), 32'(d != 0));
      check("rdata_f",  32'(rd_data_f),       32'(head));
   endtask

   task automatic model_reset();
      q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
      m_v0  = 1'b0;
      m_rd0 = 8'h00;
   endtask

   // One clock: apply inputs, advance the model at the edge, compare 1 ns later.
   task automatic step(input bit wv, input logic [7:0] wd, input bit rv, input bit cl);
      bit was_full, was_empty;
      wr_valid = wv;
      wr_data  = wd;
      rd_valid = rv;
      clear    = cl;
      @(posedge clk);
      if (cl) begin
         q.delete();
         m_ovf = 1'b0;
         m_udf = 1'b0;
         m_v0  = 1'b0;
      end else begin
         was_full  = (q.size() == 8);
         was_empty = (q.size() == 0);
         if (wv && was_full)  m_ovf = 1'b1;
         if (rv && was_empty) m_udf = 1'b1;
         m_v0 = rv && !was_empty;
         if (m_v0) m_rd0 = q.pop_front();
         if (wv && !was_full) q.push_back(wd);
      end
      #1;
      check_all();
   endtask

   initial begin
      reset_n  = 1'b0;
      wr_valid = 1'b0;
      wr_data  = 8'h00;
      rd_valid = 1'b0;
      clear    = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      reset_n = 1'b1;

      // Fill with 0x01..0x08, then one overflowing write.
      for (int i = 1; i <= 8; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
      step(1'b1, 8'hEE, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);

      // Drain the eight words, then one underflowing read.
      for (int i = 0; i < 9; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b1);

      // FWFT visibility of a single word, then pop to empty.
      step(1'b1, 8'hA5, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);

      // Depth 4 steady state through simultaneous read/write across pointer wrap.
      for (int i = 0; i < 4; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) step(1'b1, 8'($urandom), 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

      // Depth 5 with overflow pending, then clear racing a read and a write.
      for (int i = 0; i < 9; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b1, 8'h5A, 1'b1, 1'b1);
      step(1'b0, 8'h00, 1'b0, 1'b0);

      // Random traffic with occasional clears.
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 99) < 55, 8'($urandom),
              $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 3);
      end

      // Asynchronous reset mid-burst at depth 3, checked before the next edge.
      step(1'b0, 8'h00, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
      step(1'b1, 8'h77, 1'b1, 1'b0);
      wr_valid = 1'b0;
      rd_valid = 1'b0;
      #1;
      reset_n = 1'b0;
      #1;
      model_reset();
      check_all();
      #2;
      reset_n = 1'b1;
      step(1'b1, 8'h3C, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
